// File: rtl/reset_sequencer.sv
// reset_sequencer: synchronized, filtered, stretched and staggered multi-channel reset release
// Ports:
//   clk          single clock
//   rst          synchronous active-high block reset, highest priority
//   asyncRstn    asynchronous active-low external reset request
//   swRst        synchronous software reset, one-cycle pulse is enough
//   syncRstn     active-low channel resets, bit 0 released first
//   allReleased  high once every channel is released
//   busy         inverse of allReleased
//   rstCause     cause of the last reset: bit0 hardware, bit1 software, 00 block reset
module reset_sequencer #(
  parameter int CHANNELS = 4,
  parameter int FLOPS    = 2,
  parameter int FILTER   = 2,
  parameter int HOLD     = 16,
  parameter int STAGGER  = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                asyncRstn,
  input  logic                swRst,
  output logic [CHANNELS-1:0] syncRstn,
  output logic                allReleased,
  output logic                busy,
  output logic [1:0]          rstCause
);
  localparam int LW = $clog2(FILTER + 1);
  localparam int HW = HOLD > 1 ? $clog2(HOLD) : 1;
  localparam int SW = STAGGER > 1 ? $clog2(STAGGER) : 1;
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam logic [LW-1:0] LMAX = LW'(FILTER);
  localparam logic [HW-1:0] HMAX = HW'(HOLD - 1);
  localparam logic [SW-1:0] SMAX = SW'(STAGGER - 1);
  localparam logic [CW-1:0] CMAX = CW'(CHANNELS - 1);
  localparam logic [CHANNELS-1:0] ONE = CHANNELS'(1);

  typedef enum logic [1:0] {ST_ASSERT, ST_RELEASE, ST_RUN} state_t;

  state_t state_q, state_d;
  logic [FLOPS-1:0] sync_q;
  logic [LW-1:0] low_q, low_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] stag_q, stag_d;
  logic [CW-1:0] chan_q, chan_d;
  logic [CHANNELS-1:0] rstn_q, rstn_d;
  logic [1:0] cause_q, cause_d, cause_bits;
  logic all_q, all_d, busy_q, boot_q;
  logic sync_out, hw_evt, evt;

  assign sync_out = sync_q[FLOPS-1];
  assign low_d = sync_out ? '0 : (low_q == LMAX ? low_q : low_q + 1'b1);
  assign hw_evt = low_q == LMAX;
  assign evt = hw_evt | swRst;
  // The preloaded-low synchronizer after rst looks like a hardware request until it
  // first clears; boot_q keeps that artefact from being reported as a hardware cause.
  assign cause_bits = {swRst, hw_evt & ~boot_q};

  always_comb begin
    state_d = state_q;
    hold_d = hold_q;
    stag_d = stag_q;
    chan_d = chan_q;
    rstn_d = rstn_q;
    cause_d = cause_q;
    if (evt) begin
      state_d = ST_ASSERT;
      hold_d = '0;
      stag_d = '0;
      chan_d = '0;
      rstn_d = '0;
      cause_d = state_q == ST_ASSERT ? cause_q | cause_bits : cause_bits;
    end else if (state_q == ST_ASSERT) begin
      if (hold_q == HMAX) begin
        rstn_d = ONE;
        chan_d = CW'(1);
        stag_d = '0;
        state_d = CHANNELS == 1 ? ST_RUN : ST_RELEASE;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end else if (state_q == ST_RELEASE) begin
      stag_d = stag_q + 1'b1;
      if (stag_q == SMAX) begin
        rstn_d = rstn_q | (ONE << chan_q);
        stag_d = '0;
        chan_d = chan_q == CMAX ? '0 : chan_q + 1'b1;
        state_d = chan_q == CMAX ? ST_RUN : ST_RELEASE;
      end
    end
    all_d = state_d == ST_RUN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      low_q <= LMAX;
      boot_q <= 1'b1;
      state_q <= ST_ASSERT;
      hold_q <= '0;
      stag_q <= '0;
      chan_q <= '0;
      rstn_q <= '0;
      cause_q <= '0;
      all_q <= 1'b0;
      busy_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[FLOPS-2:0], asyncRstn};
      low_q <= low_d;
      boot_q <= boot_q & hw_evt;
      state_q <= state_d;
      hold_q <= hold_d;
      stag_q <= stag_d;
      chan_q <= chan_d;
      rstn_q <= rstn_d;
      cause_q <= cause_d;
      all_q <= all_d;
      busy_q <= ~all_d;
    end
  end

  assign syncRstn = rstn_q;
  assign allReleased = all_q;
  assign busy = busy_q;
  assign rstCause = cause_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench for default, FILTER=1 and CHANNELS=1 sequencers
module tb_reset_sequencer;
  typedef struct {
    int unsigned e;
    logic [7:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic [2:0] rst_v, ar_v, sw_v;
  logic [3:0] s0, s1;
  logic [0:0] s2;
  logic ar0, ar1, ar2, bz0, bz1, bz2;
  logic [1:0] c0, c1, c2;
  logic [2:0][7:0] obs;
  logic [2:0][7:0] prev;
  logic mon_en = 1'b0;
  int unsigned cyc = 0;
  int checks = 0;
  int fails = 0;
  exp_t q[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reset_sequencer u0 (.clk(clk), .rst(rst_v[0]), .asyncRstn(ar_v[0]), .swRst(sw_v[0]),
    .syncRstn(s0), .allReleased(ar0), .busy(bz0), .rstCause(c0));
  reset_sequencer #(.FILTER(1)) u1 (.clk(clk), .rst(rst_v[1]), .asyncRstn(ar_v[1]), .swRst(sw_v[1]),
    .syncRstn(s1), .allReleased(ar1), .busy(bz1), .rstCause(c1));
  reset_sequencer #(.CHANNELS(1)) u2 (.clk(clk), .rst(rst_v[2]), .asyncRstn(ar_v[2]), .swRst(sw_v[2]),
    .syncRstn(s2), .allReleased(ar2), .busy(bz2), .rstCause(c2));

  assign obs[0] = {s0, ar0, bz0, c0};
  assign obs[1] = {s1, ar1, bz1, c1};
  assign obs[2] = {3'b000, s2, ar2, bz2, c2};

  function automatic logic [7:0] V(input logic [3:0] s, input logic a, input logic [1:0] c);
    return {s, a, ~a, c};
  endfunction

  task automatic ex(input int i, input int unsigned e, input logic [7:0] v);
    q[i].push_back('{e, v});
  endtask

  task automatic nxt(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input int i, input string nm, input logic [7:0] v);
    checks++;
    if (obs[i] !== v) begin
      fails++;
      $display("FAIL %s dut%0d: got %b, required %b", nm, i, obs[i], v);
    end
  endtask

  task automatic drain(input int i, input int budget);
    int n = 0;
    while (q[i].size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (q[i].size() != 0) begin
      fails++;
      $display("FAIL drain dut%0d: %0d expected changes never seen, required 0", i, q[i].size());
      q[i].delete();
    end
  endtask

  task automatic powerup(input int i, input logic [1:0] c);
    int unsigned b = cyc + 1;
    rst_v[i] = 1'b0;
    ex(i, b + 18, V(4'b0001, 0, c));
    ex(i, b + 26, V(4'b0011, 0, c));
    ex(i, b + 34, V(4'b0111, 0, c));
    ex(i, b + 42, V(4'b1111, 1, c));
  endtask

  initial begin
    exp_t x;
    wait (mon_en);
    prev = obs;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (obs[i] !== prev[i]) begin
          checks++;
          if (q[i].size() == 0) begin
            fails++;
            $display("FAIL mon dut%0d: got change to %b at cycle %0d, required no change", i, obs[i], cyc);
          end else begin
            x = q[i].pop_front();
            if (x.e != cyc || x.v !== obs[i]) begin
              fails++;
              $display("FAIL mon dut%0d: got %b at cycle %0d, required %b at cycle %0d", i, obs[i], cyc, x.v, x.e);
            end
          end
          prev[i] = obs[i];
        end
      end
    end
  end

  initial begin
    int unsigned a, s;
    rst_v = 3'b111;
    ar_v = 3'b111;
    sw_v = 3'b000;
    nxt(3);
    for (int i = 0; i < 3; i++) chk(i, "reset", V(4'b0000, 0, 2'b00));
    mon_en = 1'b1;
    powerup(0, 2'b00);
    drain(0, 60);
    chk(0, "powerup_run", V(4'b1111, 1, 2'b00));
    ar_v[0] = 1'b0;
    nxt(1);
    ar_v[0] = 1'b1;
    nxt(12);
    chk(0, "glitch", V(4'b1111, 1, 2'b00));
    a = cyc + 1;
    ar_v[0] = 1'b0;
    ex(0, a + 4, V(4'b0000, 0, 2'b01));
    nxt(10);
    ar_v[0] = 1'b1;
    ex(0, a + 28, V(4'b0001, 0, 2'b01));
    ex(0, a + 36, V(4'b0011, 0, 2'b01));
    ex(0, a + 44, V(4'b0111, 0, 2'b01));
    ex(0, a + 52, V(4'b1111, 1, 2'b01));
    drain(0, 80);
    s = cyc + 1;
    sw_v[0] = 1'b1;
    ex(0, s, V(4'b0000, 0, 2'b10));
    nxt(1);
    sw_v[0] = 1'b0;
    ex(0, s + 16, V(4'b0001, 0, 2'b10));
    nxt(int'(s + 24 - (cyc + 1)));
    s = s + 24;
    sw_v[0] = 1'b1;
    ex(0, s, V(4'b0000, 0, 2'b10));
    nxt(1);
    sw_v[0] = 1'b0;
    ex(0, s + 16, V(4'b0001, 0, 2'b10));
    ex(0, s + 24, V(4'b0011, 0, 2'b10));
    ex(0, s + 32, V(4'b0111, 0, 2'b10));
    ex(0, s + 40, V(4'b1111, 1, 2'b10));
    drain(0, 60);
    a = cyc + 1;
    ar_v[0] = 1'b0;
    nxt(3);
    sw_v[0] = 1'b1;
    ex(0, a + 3, V(4'b0000, 0, 2'b10));
    ex(0, a + 4, V(4'b0000, 0, 2'b11));
    nxt(1);
    sw_v[0] = 1'b0;
    ar_v[0] = 1'b1;
    ex(0, a + 22, V(4'b0001, 0, 2'b11));
    ex(0, a + 30, V(4'b0011, 0, 2'b11));
    ex(0, a + 38, V(4'b0111, 0, 2'b11));
    ex(0, a + 46, V(4'b1111, 1, 2'b11));
    drain(0, 70);
    s = cyc + 1;
    sw_v[0] = 1'b1;
    ex(0, s, V(4'b0000, 0, 2'b10));
    nxt(1);
    sw_v[0] = 1'b0;
    ex(0, s + 16, V(4'b0001, 0, 2'b10));
    ex(0, s + 24, V(4'b0011, 0, 2'b10));
    nxt(int'(s + 28 - (cyc + 1)));
    rst_v[0] = 1'b1;
    ex(0, s + 28, V(4'b0000, 0, 2'b00));
    nxt(1);
    powerup(0, 2'b00);
    drain(0, 80);
    powerup(1, 2'b00);
    drain(1, 60);
    a = cyc + 1;
    ar_v[1] = 1'b0;
    nxt(1);
    ar_v[1] = 1'b1;
    ex(1, a + 3, V(4'b0000, 0, 2'b01));
    ex(1, a + 19, V(4'b0001, 0, 2'b01));
    ex(1, a + 27, V(4'b0011, 0, 2'b01));
    ex(1, a + 35, V(4'b0111, 0, 2'b01));
    ex(1, a + 43, V(4'b1111, 1, 2'b01));
    drain(1, 60);
    a = cyc + 1;
    rst_v[2] = 1'b0;
    ex(2, a + 18, V(4'b0001, 1, 2'b00));
    drain(2, 30);
    s = cyc + 1;
    sw_v[2] = 1'b1;
    ex(2, s, V(4'b0000, 0, 2'b10));
    nxt(1);
    sw_v[2] = 1'b0;
    ex(2, s + 16, V(4'b0001, 1, 2'b10));
    drain(2, 30);
    nxt(4);
    chk(0, "final0", V(4'b1111, 1, 2'b00));
    chk(1, "final1", V(4'b1111, 1, 2'b01));
    chk(2, "final2", V(4'b0001, 1, 2'b10));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
